// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: up/down modulo counter controller driving a downstream T flip-flop bank
// via per-bit toggle enables, with one-shot halt, synchronous load and terminal-count pulse.
module tff_count_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] mod_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] t_out,
   output logic             tc,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
   localparam logic [WIDTH-1:0] ONE = 1;
   state_t st, cur, nxt;
   logic advance, wrap;
   logic [WIDTH-1:0] step, q_next;
   always_comb begin
      cur     = (st == state_t'(2'b11)) ? IDLE : st;
      advance = (cur == RUN) && en && !load;
      // out-of-range q wraps immediately going up but counts down normally
      wrap    = advance && (up ? (q >= mod_val) : (q == '0));
      step    = up ? ((q >= mod_val) ? '0 : q + ONE) : ((q == '0) ? mod_val : q - ONE);
      q_next  = load ? din : (advance ? step : q);
      // gated by clr so the toggle bank sees nothing while reset is held
      t_out   = (clr && (load || advance)) ? (q ^ q_next) : '0;
      nxt     = cur;
      if (load)
         nxt = en ? RUN : IDLE;
      else if (cur == IDLE)
         nxt = en ? RUN : IDLE;
      else if (cur == RUN)
         nxt = !en ? IDLE : ((wrap && oneshot) ? HALT : RUN);
      else
         nxt = en ? HALT : IDLE;
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         st <= IDLE;
         q  <= '0;
         tc <= 1'b0;
      end else begin
         st <= nxt;
         q  <= q_next;
         tc <= wrap;
      end
   end
   assign state = cur;
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: directed vectors push expected outputs into a scoreboard queue;
// a monitor pops and compares them mid-cycle, away from the rising edge.
module tb_tff_count_ctrl;
   logic clk = 1'b0, clr = 1'b0, en = 1'b0, up = 1'b0, oneshot = 1'b0, load = 1'b0;
   logic [3:0] din = '0, mod_val = '0;
   logic [3:0] q, t_out;
   logic tc;
   logic [1:0] state;
   typedef struct {
      logic [3:0] q;
      logic       tc;
      logic [1:0] st;
      logic [3:0] t;
      int         id;
   } exp_t;
   exp_t sb[$];
   int compared = 0, mismatched = 0, vec_n = 0;
   bit done = 1'b0;

   tff_count_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .clr(clr), .en(en), .up(up), .oneshot(oneshot), .load(load),
      .din(din), .mod_val(mod_val), .q(q), .t_out(t_out), .tc(tc), .state(state)
   );

   always #5 clk = ~clk;

   task automatic v(input logic c, e, u, o, l, input logic [3:0] d, m,
                    input logic [3:0] eq, input logic etc, input logic [1:0] es, input logic [3:0] et);
      @(posedge clk);
      #2;
      clr = c; en = e; up = u; oneshot = o; load = l; din = d; mod_val = m;
      sb.push_back('{eq, etc, es, et, vec_n});
      vec_n++;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         compared++;
         if ({q, tc, state, t_out} !== {x.q, x.tc, x.st, x.t}) begin
            mismatched++;
            $display("FAIL vec%0d: got q=%h tc=%b state=%b t_out=%b, expected q=%h tc=%b state=%b t_out=%b",
                     x.id, q, tc, state, t_out, x.q, x.tc, x.st, x.t);
         end
      end
   end

   initial begin
      // reset holds everything at zero even with load/en asserted
      //   clr en up os ld din    mod     q      tc    st     t_out
      v(0, 1, 0, 0, 1, 4'd5,  4'd0,  4'd0,  0, 2'b00, 4'b0000);
      // free-run up, mod 6
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd0,  0, 2'b00, 4'b0000);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd0,  0, 2'b01, 4'b0001);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd1,  0, 2'b01, 4'b0011);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd2,  0, 2'b01, 4'b0001);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd3,  0, 2'b01, 4'b0111);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd4,  0, 2'b01, 4'b0001);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd5,  0, 2'b01, 4'b0101);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd0,  1, 2'b01, 4'b0001);
      // load 2 while running, then down with mod 10
      v(1, 1, 1, 0, 1, 4'd2,  4'd5,  4'd1,  0, 2'b01, 4'b0011);
      v(1, 1, 0, 0, 0, 4'd0,  4'd9,  4'd2,  0, 2'b01, 4'b0011);
      v(1, 1, 0, 0, 0, 4'd0,  4'd9,  4'd1,  0, 2'b01, 4'b0001);
      v(1, 1, 0, 0, 0, 4'd0,  4'd9,  4'd0,  0, 2'b01, 4'b1001);
      v(1, 1, 0, 0, 0, 4'd0,  4'd9,  4'd9,  1, 2'b01, 4'b0001);
      v(1, 0, 0, 0, 0, 4'd0,  4'd9,  4'd8,  0, 2'b01, 4'b0000);
      v(1, 0, 0, 0, 0, 4'd0,  4'd9,  4'd8,  0, 2'b00, 4'b0000);
      // load and en together in IDLE: load wins, then one-shot mod 4
      v(1, 1, 1, 1, 1, 4'd0,  4'd3,  4'd8,  0, 2'b00, 4'b1000);
      v(1, 1, 1, 1, 0, 4'd0,  4'd3,  4'd0,  0, 2'b01, 4'b0001);
      v(1, 1, 1, 1, 0, 4'd0,  4'd3,  4'd1,  0, 2'b01, 4'b0011);
      v(1, 1, 1, 1, 0, 4'd0,  4'd3,  4'd2,  0, 2'b01, 4'b0001);
      v(1, 1, 1, 1, 0, 4'd0,  4'd3,  4'd3,  0, 2'b01, 4'b0011);
      v(1, 1, 1, 1, 0, 4'd0,  4'd3,  4'd0,  1, 2'b10, 4'b0000);
      v(1, 1, 1, 1, 0, 4'd0,  4'd3,  4'd0,  0, 2'b10, 4'b0000);
      // load exits HALT
      v(1, 1, 1, 1, 1, 4'd7,  4'd3,  4'd0,  0, 2'b10, 4'b0111);
      v(1, 0, 1, 0, 0, 4'd0,  4'd3,  4'd7,  0, 2'b01, 4'b0000);
      // out-of-range load 12 with mod 6: up wraps at once, down counts through
      v(1, 1, 1, 0, 1, 4'd12, 4'd5,  4'd7,  0, 2'b00, 4'b1011);
      v(1, 1, 1, 0, 0, 4'd0,  4'd5,  4'd12, 0, 2'b01, 4'b1100);
      v(1, 1, 0, 0, 1, 4'd12, 4'd5,  4'd0,  1, 2'b01, 4'b1100);
      v(1, 1, 0, 0, 0, 4'd0,  4'd5,  4'd12, 0, 2'b01, 4'b0111);
      v(1, 1, 0, 0, 0, 4'd0,  4'd5,  4'd11, 0, 2'b01, 4'b0001);
      v(1, 1, 0, 0, 0, 4'd0,  4'd5,  4'd10, 0, 2'b01, 4'b0011);
      v(1, 1, 0, 0, 0, 4'd0,  4'd5,  4'd9,  0, 2'b01, 4'b0001);
      v(1, 1, 0, 0, 0, 4'd0,  4'd5,  4'd8,  0, 2'b01, 4'b1111);
      v(1, 1, 0, 0, 0, 4'd0,  4'd5,  4'd7,  0, 2'b01, 4'b0001);
      v(1, 1, 0, 0, 0, 4'd0,  4'd5,  4'd6,  0, 2'b01, 4'b0011);
      v(1, 0, 0, 0, 0, 4'd0,  4'd5,  4'd5,  0, 2'b01, 4'b0000);
      // mod_val 0: every enabled RUN cycle wraps; then one-shot halt and HALT->IDLE
      v(1, 1, 1, 0, 1, 4'd0,  4'd0,  4'd5,  0, 2'b00, 4'b0101);
      v(1, 1, 1, 0, 0, 4'd0,  4'd0,  4'd0,  0, 2'b01, 4'b0000);
      v(1, 1, 1, 0, 0, 4'd0,  4'd0,  4'd0,  1, 2'b01, 4'b0000);
      v(1, 1, 1, 1, 0, 4'd0,  4'd0,  4'd0,  1, 2'b01, 4'b0000);
      v(1, 1, 1, 1, 0, 4'd0,  4'd0,  4'd0,  1, 2'b10, 4'b0000);
      v(1, 0, 1, 1, 0, 4'd0,  4'd0,  4'd0,  0, 2'b10, 4'b0000);
      v(1, 0, 1, 0, 0, 4'd0,  4'd0,  4'd0,  0, 2'b00, 4'b0000);
      // reset mid-run at q=4, then resume from 0
      v(1, 1, 1, 0, 1, 4'd3,  4'd9,  4'd0,  0, 2'b00, 4'b0011);
      v(1, 1, 1, 0, 0, 4'd0,  4'd9,  4'd3,  0, 2'b01, 4'b0111);
      v(0, 1, 1, 0, 0, 4'd0,  4'd9,  4'd0,  0, 2'b00, 4'b0000);
      v(0, 1, 1, 0, 0, 4'd0,  4'd9,  4'd0,  0, 2'b00, 4'b0000);
      v(1, 1, 1, 0, 0, 4'd0,  4'd9,  4'd0,  0, 2'b00, 4'b0000);
      v(1, 1, 1, 0, 0, 4'd0,  4'd9,  4'd0,  0, 2'b01, 4'b0001);
      v(1, 0, 1, 0, 0, 4'd0,  4'd9,  4'd1,  0, 2'b01, 4'b0000);
      v(1, 0, 1, 0, 0, 4'd0,  4'd9,  4'd1,  0, 2'b00, 4'b0000);
      // wrap interrupted by reset: tc must stay low afterwards
      v(1, 1, 1, 0, 1, 4'd0,  4'd0,  4'd1,  0, 2'b00, 4'b0001);
      v(0, 1, 1, 0, 0, 4'd0,  4'd0,  4'd0,  0, 2'b00, 4'b0000);
      v(1, 0, 1, 0, 0, 4'd0,  4'd0,  4'd0,  0, 2'b00, 4'b0000);
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      end
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #20000;
      if (!done) begin
         $display("FAIL timeout: run did not complete, expected completion");
         $fatal(1, "timeout");
      end
   end
endmodule
